// File: rtl/fpdiv_ctrl.sv
// -----------------------------------------------------------------------------
// fpdiv_ctrl
//   Sequencing controller for the Goldschmidt floating-point divider datapath.
//   A start request runs one complete division:
//     N0/D0   initial-approximation multiplies (IA x N, IA x D)
//     NI/DI   N/D refinement iterations (C x N, C x D)
//     REM     remainder / rounding step
//     DONE    one-cycle completion pulse
//   The block then returns to IDLE, or goes straight back to N0 when start is
//   still requested.
//
//   Optional feature macro: FPDIV_CTRL_COUNT_EN
//     defined   : div_count counts completed divisions (wraps at 2^16) and is
//                 cleared only by reset.
//     undefined : div_count is tied to zero and no counter flops exist.
//
// Parameters
//   ITERS      total N/D multiply iterations including the initial one (2..15)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   start      division request, sampled only in IDLE or DONE
//   rm_in      rounding-mode bit, captured when start is accepted
//   busy       high from the first multiply cycle through the REM cycle
//   done       one-cycle pulse after the REM cycle
//   rm         captured rounding mode towards fpdiv
//   sel_mux4   multiplier operand select (00 IAxN, 01 IAxD, 10 CxN, 11 CxD)
//   sel_mux3   factor select (00 IA, 01 C register, 10 remainder path)
//   en_a       load numerator/quotient register A
//   en_b       load denominator register B
//   en_rem     load remainder register
//   div_count  completed-division counter
// -----------------------------------------------------------------------------
module fpdiv_ctrl #(
    parameter int ITERS = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rm_in,
    output logic        busy,
    output logic        done,
    output logic        rm,
    output logic [1:0]  sel_mux4,
    output logic [1:0]  sel_mux3,
    output logic        en_a,
    output logic        en_b,
    output logic        en_rem,
    output logic [15:0] div_count
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_N0   = 3'd1;
    localparam logic [2:0] S_D0   = 3'd2;
    localparam logic [2:0] S_NI   = 3'd3;
    localparam logic [2:0] S_DI   = 3'd4;
    localparam logic [2:0] S_REM  = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    localparam logic [3:0] ITERS_W = 4'(ITERS);

    // Output vector layout: {busy, done, sel_mux4[1:0], sel_mux3[1:0], en_a, en_b, en_rem}
    function automatic logic [8:0] decode_outputs(input logic [2:0] st);
        logic [8:0] v;
        case (st)
            S_IDLE:  v = {1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
            S_N0:    v = {1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
            S_D0:    v = {1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0};
            S_NI:    v = {1'b1, 1'b0, 2'b10, 2'b01, 1'b1, 1'b0, 1'b0};
            S_DI:    v = {1'b1, 1'b0, 2'b11, 2'b01, 1'b0, 1'b1, 1'b0};
            S_REM:   v = {1'b1, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 1'b1};
            S_DONE:  v = {1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
            default: v = {1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        endcase
        return v;
    endfunction

    logic [2:0] state_r;
    logic [2:0] state_next_s;
    logic [3:0] it_r;
    logic [3:0] it_next_s;
    logic [3:0] it_inc_s;
    logic       accept_s;
    logic       rm_r;
    logic [8:0] out_r;

    // start is only honoured between divisions; it is ignored while busy
    assign accept_s = ((state_r == S_IDLE) || (state_r == S_DONE)) && start;
    assign it_inc_s = it_r + 4'd1;

    // Next-state and iteration-counter logic
    always_comb begin
        state_next_s = state_r;
        it_next_s    = it_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_next_s = S_N0;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_N0: begin
                state_next_s = S_D0;
            end
            S_D0: begin
                state_next_s = S_NI;
                it_next_s    = 4'd1;
            end
            S_NI: begin
                state_next_s = S_DI;
            end
            S_DI: begin
                // it counts completed N/D pairs including the initial one
                if (it_inc_s < ITERS_W) begin
                    state_next_s = S_NI;
                    it_next_s    = it_inc_s;
                end else begin
                    state_next_s = S_REM;
                end
            end
            S_REM: begin
                state_next_s = S_DONE;
            end
            S_DONE: begin
                if (start) begin
                    state_next_s = S_N0;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            default: begin
                state_next_s = S_IDLE;
                it_next_s    = 4'd0;
            end
        endcase
    end

    // State, iteration counter and rounding-mode capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
            it_r    <= 4'd0;
            rm_r    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            it_r    <= it_next_s;
            if (accept_s) begin
                rm_r <= rm_in;
            end else begin
                rm_r <= rm_r;
            end
        end
    end

    // Output flops load the decode of the next state, so they always equal the
    // decode of the current registered state with no path from start to a pin
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_r <= 9'd0;
        end else begin
            out_r <= decode_outputs(state_next_s);
        end
    end

    assign busy     = out_r[8];
    assign done     = out_r[7];
    assign sel_mux4 = out_r[6:5];
    assign sel_mux3 = out_r[4:3];
    assign en_a     = out_r[2];
    assign en_b     = out_r[1];
    assign en_rem   = out_r[0];
    assign rm       = rm_r;

`ifdef FPDIV_CTRL_COUNT_EN
    logic [15:0] count_r;

    // Completed-division counter, advanced on every REM->DONE transition
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= 16'd0;
        end else if (state_r == S_REM) begin
            count_r <= count_r + 16'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign div_count = count_r;
`else
    assign div_count = 16'd0;
`endif

endmodule

// File: doc/fpdiv_ctrl.md
# fpdiv_ctrl

Sequencing controller for the Goldschmidt floating-point divider datapath (`fpdiv`). On a `start` request it drives the divider's operand-mux selects and register enables through one division:
- the initial-approximation multiplies;
- the N/D refinement iterations;
- the remainder/rounding step.

It then signals `done`. It replaces hand-driven select/enable sequencing and is the only block allowed to drive those `fpdiv` controls.

## Interface
- `ITERS`, default 6: total N/D multiply iterations, including the initial-approximation iteration; legal range 2..15.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: request a division; sampled only in IDLE or DONE.
- `rm_in` input 1: rounding-mode bit; latched when `start` is accepted.
- `busy` output 1: high from the first multiply cycle through the REM cycle.
- `done` output 1: one-cycle pulse after the REM cycle.
- `rm` output 1: latched rounding mode to `fpdiv`.
- `sel_mux4` output 2: multiplier operand select (00 IA×N, 01 IA×D, 10 C×N, 11 C×D).
- `sel_mux3` output 2: factor select (00 IA, 01 C register, 10 remainder path).
- `en_a` output 1: load numerator/quotient register A.
- `en_b` output 1: load denominator register B.
- `en_rem` output 1: load remainder register.
- `div_count` output 16: completed-division counter; see Configuration.

## Operation
- States: IDLE, N0, D0, NI, DI, REM, DONE. State is encoded in 3 bits, with a separate iteration counter `it` of 4 bits.
- Per-state outputs, written as sel_mux4 / sel_mux3 / enable:
  - IDLE: 00 / 00, all enables 0.
  - N0: 00 / 00, `en_a`=1.
  - D0: 01 / 00, `en_b`=1.
  - NI: 10 / 01, `en_a`=1.
  - DI: 11 / 01, `en_b`=1.
  - REM: 10 / 10, `en_rem`=1.
  - DONE: 00 / 00, `done`=1.
- Transitions:
  - IDLE→N0 on `start`; N0→D0 unconditionally.
  - D0→NI with `it`←1.
  - NI→DI unconditionally.
  - DI→NI with `it`←`it`+1 while `it`+1 < ITERS; otherwise DI→REM.
  - REM→DONE unconditionally.
  - DONE→N0 if `start`, else DONE→IDLE.
- Exactly one of `en_a`/`en_b`/`en_rem` is high in any non-idle state; none is high in IDLE or DONE.
- `rm` is loaded from `rm_in` on accepted `start` only and holds its value otherwise, including across DONE→IDLE.
- `start` in N0..REM is ignored: no queuing, no restart, `rm` unchanged.
- `busy` = state ∈ {N0, D0, NI, DI, REM}.

## Timing
- Reset values: state IDLE, `it`=0, `rm`=0, `busy`=0, `done`=0, `sel_mux4`=00, `sel_mux3`=00, all enables 0, `div_count`=0.
- All outputs are decoded from registered state (Moore machine); no combinational path from `start` to any output.
- Latency: with `start` sampled at edge t0, N0 occupies cycle t0+1.
  - Busy cycles: 2 + 2·(ITERS−1) + 1 = 2·ITERS+1, which is 13 for ITERS=6.
  - `done` is high in cycle t0+2·ITERS+2, which is cycle 14 for ITERS=6.
- Throughput: back-to-back `start` in DONE gives a new N0 immediately, for a 2·ITERS+2 cycle period.
- Reset asserted mid-operation forces all outputs to reset values asynchronously. The datapath register contents are then don't-care; the next `start` after deassertion runs a full sequence.
- `start` held high continuously produces repeated divisions with period 2·ITERS+2 and no IDLE cycles.

## Configuration
- Macro: `FPDIV_CTRL_COUNT_EN`.
- Defined: `div_count` increments by 1, wrapping modulo 2^16, on every REM→DONE transition, and is cleared only by `reset`.
- Undefined: `div_count` is tied to 0, no counter flops exist, and the port list is unchanged.

## Test plan
- Reset: assert `reset` with `start`=1 → every output at its reset value, state stays IDLE while `reset` is high.
- Single division, ITERS=6, `rm_in`=1, one-cycle `start`:
  - 13 busy cycles with select/enable trace 00/00/a, 01/00/b, then 5×(10/01/a, 11/01/b), then 10/10/rem.
  - `done` high exactly in cycle 14 only; `rm`=1 thereafter.
- `start` pulsed during NI with `rm_in`=0 → sequence unaffected, `done` still at cycle 14, `rm` stays 1.
- `start` held high for 3 divisions → `done` at cycles 14, 28, 42, with no cycle where `busy`=0 and `done`=0 in between.
- Async `reset` during the second DI → outputs zero within the same cycle without a clock edge; a fresh `start` then yields a full 13-cycle trace.
- With `FPDIV_CTRL_COUNT_EN` defined, 2 completed divisions plus 1 aborted by reset: `div_count`=2 before the reset and 0 after it. Without the macro, `div_count`=0 throughout.
